// File: rtl/lcd_bus_capture.sv
// rtl/lcd_bus_capture.sv - Model 100 LCD bus responder mirroring column-driver writes into a framebuffer
//
// Purpose:
//   Watches the mainboard CPU's accesses to the ten column-driver chips on the LCD
//   connector. Every display-data write is forwarded as a one-cycle framebuffer write.
//   Commands update a per-chip copy of the driver state. Status reads are answered
//   with "never busy".
//
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   bus_data/cs/rw/di  LCD bus from the mainboard; all asynchronous to clk
//   bus_enable         strobe; the transfer is taken on its falling edge
//   bus_reset_n        panel reset from the mainboard, active-low
//   data_out, data_oe  status byte and pad enable driven back to the CPU
//   fb_we, fb_chip,
//   fb_page, fb_col,
//   fb_data            framebuffer write port (one-cycle strobe)
//   display_on         per-chip display-on flag
//   overrun            sticky; a strobe arrived while a dispatch was still running

module lcd_bus_capture #(
    parameter int NUM_CHIPS   = 10,
    parameter int NUM_COLS    = 50,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           bus_data,
    input  logic [NUM_CHIPS-1:0] bus_cs,
    input  logic                 bus_rw,
    input  logic                 bus_di,
    input  logic                 bus_enable,
    input  logic                 bus_reset_n,
    output logic [7:0]           data_out,
    output logic                 data_oe,
    output logic                 fb_we,
    output logic [3:0]           fb_chip,
    output logic [1:0]           fb_page,
    output logic [5:0]           fb_col,
    output logic [7:0]           fb_data,
    output logic [NUM_CHIPS-1:0] display_on,
    output logic                 overrun
);

    // Bit layout of the synchronized bus word.
    localparam int W_IN   = 12 + NUM_CHIPS;
    localparam int B_CS   = 8;
    localparam int B_RW   = 8 + NUM_CHIPS;
    localparam int B_DI   = 9 + NUM_CHIPS;
    localparam int B_EN   = 10 + NUM_CHIPS;
    localparam int B_RSTN = 11 + NUM_CHIPS;

    // The panel-reset bit comes out of reset inactive (high) so that the
    // chips are not held in reset while the synchronizer fills.
    localparam logic [W_IN-1:0] SYNC_INIT = {1'b1, {(W_IN-1){1'b0}}};

    localparam logic [3:0] LAST_IDX = 4'(NUM_CHIPS - 1);
    localparam logic [5:0] COL_MAX  = 6'(NUM_COLS - 1);
    localparam logic [6:0] COL_LIM  = 7'(NUM_COLS);

    typedef enum logic {
        S_IDLE,
        S_DISPATCH
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [W_IN-1:0] r_sync [SYNC_STAGES];
    logic [W_IN-1:0] w_bus_in;
    logic [W_IN-1:0] w_sync;

    assign w_bus_in = {bus_reset_n, bus_enable, bus_di, bus_rw, bus_cs, bus_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= SYNC_INIT;
            end
        end else begin
            r_sync[0] <= w_bus_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    logic [7:0]           w_data;
    logic [NUM_CHIPS-1:0] w_cs;
    logic                 w_rw;
    logic                 w_di;
    logic                 w_en;
    logic                 w_rstn;

    assign w_data = w_sync[7:0];
    assign w_cs   = w_sync[B_CS +: NUM_CHIPS];
    assign w_rw   = w_sync[B_RW];
    assign w_di   = w_sync[B_DI];
    assign w_en   = w_sync[B_EN];
    assign w_rstn = w_sync[B_RSTN];

    logic r_en_d;
    logic w_fall;
    logic w_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en_d <= 1'b0;
        end else begin
            r_en_d <= w_en;
        end
    end

    // A strobe only counts while the panel is out of reset.
    assign w_fall = r_en_d & ~w_en & w_rstn;
    assign w_rise = ~r_en_d & w_en;

    // ------------------------------------------------------------------
    // Dispatch FSM
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;
    logic [3:0]           r_idx;
    logic [NUM_CHIPS-1:0] r_lat_cs;
    logic [7:0]           r_lat_data;
    logic                 r_lat_di;
    logic                 w_start;
    logic                 w_act;
    logic                 w_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_act        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall && !w_rw) begin
                    w_start      = 1'b1;
                    w_state_next = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                // Panel reset aborts the sweep; the chip in hand is dropped too.
                w_act = w_rstn & r_lat_cs[r_idx];
                if (!w_rstn || r_idx == LAST_IDX) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_we = w_act & r_lat_di;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx      <= 4'd0;
            r_lat_cs   <= '0;
            r_lat_data <= 8'd0;
            r_lat_di   <= 1'b0;
        end else begin
            if (w_start) begin
                r_lat_cs   <= w_cs;
                r_lat_data <= w_data;
                r_lat_di   <= w_di;
            end
            if (r_state == S_DISPATCH) begin
                r_idx <= r_idx + 4'd1;
            end else begin
                r_idx <= 4'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-chip driver state
    // ------------------------------------------------------------------
    logic [1:0] r_page  [NUM_CHIPS];
    logic [5:0] r_col   [NUM_CHIPS];
    logic       r_up    [NUM_CHIPS];
    logic       r_on    [NUM_CHIPS];
    logic [1:0] r_start [NUM_CHIPS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHIPS; i++) begin
                r_page[i]  <= 2'd0;
                r_col[i]   <= 6'd0;
                r_up[i]    <= 1'b1;
                r_on[i]    <= 1'b0;
                r_start[i] <= 2'd0;
            end
        end else if (!w_rstn) begin
            for (int i = 0; i < NUM_CHIPS; i++) begin
                r_page[i]  <= 2'd0;
                r_col[i]   <= 6'd0;
                r_up[i]    <= 1'b1;
                r_on[i]    <= 1'b0;
                r_start[i] <= 2'd0;
            end
        end else if (w_act) begin
            if (r_lat_di) begin
                // Auto-step after a data write; the page never moves.
                if (r_up[r_idx]) begin
                    r_col[r_idx] <= (r_col[r_idx] == COL_MAX) ? 6'd0 : r_col[r_idx] + 6'd1;
                end else begin
                    r_col[r_idx] <= (r_col[r_idx] == 6'd0) ? COL_MAX : r_col[r_idx] - 6'd1;
                end
            end else begin
                if (r_lat_data == 8'h38) begin
                    r_on[r_idx] <= 1'b0;
                end else if (r_lat_data == 8'h39) begin
                    r_on[r_idx] <= 1'b1;
                end else if (r_lat_data == 8'h3A) begin
                    r_up[r_idx] <= 1'b0;
                end else if (r_lat_data == 8'h3B) begin
                    r_up[r_idx] <= 1'b1;
                end else if (r_lat_data[5:0] == 6'h3E) begin
                    r_start[r_idx] <= r_lat_data[7:6];
                end else if ({1'b0, r_lat_data[5:0]} < COL_LIM) begin
                    r_page[r_idx] <= r_lat_data[7:6];
                    r_col[r_idx]  <= r_lat_data[5:0];
                end
            end
        end
    end

    // Start page is tracked so the mirror matches the real driver, but the
    // framebuffer is addressed by physical page, so nothing consumes it yet.
    logic w_unused_start;

    always_comb begin
        w_unused_start = 1'b0;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            w_unused_start = w_unused_start ^ (^r_start[i]);
        end
    end

    // ------------------------------------------------------------------
    // Framebuffer port: zero whenever no write is in flight
    // ------------------------------------------------------------------
    assign fb_we   = w_we;
    assign fb_chip = w_we ? r_idx : 4'd0;
    assign fb_page = w_we ? r_page[r_idx] : 2'd0;
    assign fb_col  = w_we ? r_col[r_idx] : 6'd0;
    assign fb_data = w_we ? r_lat_data : 8'd0;

    always_comb begin
        display_on = '0;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            display_on[i] = r_on[i];
        end
    end

    // ------------------------------------------------------------------
    // Status read response
    // ------------------------------------------------------------------
    logic w_sel_up;
    logic w_sel_on;
    logic w_status;

    // With exactly one cs bit set, OR-reducing the masked flags picks that chip.
    always_comb begin
        w_sel_up = 1'b0;
        w_sel_on = 1'b0;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            w_sel_up = w_sel_up | (w_cs[i] & r_up[i]);
            w_sel_on = w_sel_on | (w_cs[i] & r_on[i]);
        end
    end

    assign w_status = (r_state == S_IDLE) & w_fall & w_rw & ~w_di & $onehot(w_cs);

    logic       r_oe;
    logic [7:0] r_dout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_oe   <= 1'b0;
            r_dout <= 8'd0;
        end else if (!w_rstn || w_rise) begin
            r_oe   <= 1'b0;
            r_dout <= 8'd0;
        end else if (w_status) begin
            r_oe   <= 1'b1;
            r_dout <= {1'b0, w_sel_up, w_sel_on, 1'b0, 4'b0000};
        end
    end

    assign data_oe  = r_oe;
    assign data_out = r_dout;

    // ------------------------------------------------------------------
    // Overrun: any strobe landing during a dispatch is dropped
    // ------------------------------------------------------------------
    logic r_overrun;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (r_state == S_DISPATCH && w_fall) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;

endmodule

// File: tb/tb_lcd_bus_capture.sv
// tb/tb_lcd_bus_capture.sv - bench for lcd_bus_capture
module tb_lcd_bus_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bus_data;
    logic [9:0] bus_cs;
    logic       bus_rw;
    logic       bus_di;
    logic       bus_enable;
    logic       bus_reset_n;
    logic [7:0] data_out;
    logic       data_oe;
    logic       fb_we;
    logic [3:0] fb_chip;
    logic [1:0] fb_page;
    logic [5:0] fb_col;
    logic [7:0] fb_data;
    logic [9:0] display_on;
    logic       overrun;

    lcd_bus_capture #(.NUM_CHIPS(10), .NUM_COLS(50), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .bus_data(bus_data), .bus_cs(bus_cs),
        .bus_rw(bus_rw), .bus_di(bus_di), .bus_enable(bus_enable),
        .bus_reset_n(bus_reset_n), .data_out(data_out), .data_oe(data_oe),
        .fb_we(fb_we), .fb_chip(fb_chip), .fb_page(fb_page), .fb_col(fb_col),
        .fb_data(fb_data), .display_on(display_on), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int n_we  = 0;

    typedef struct {
        int         at;
        logic [3:0] chip;
        logic [1:0] page;
        logic [5:0] col;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [9:0] cs;
        logic       rw;
        logic       di;
        logic [7:0] data;
        logic       rd_chk;
        logic       exp_oe;
        logic [7:0] exp_dout;
        logic [9:0] exp_on;
    } vec_t;
    vec_t tbl[24];

    logic [1:0] m_page [10];
    logic [5:0] m_col  [10];
    logic       m_up   [10];
    logic       m_on   [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 10; i++) begin
            m_page[i] = 2'd0; m_col[i] = 6'd0; m_up[i] = 1'b1; m_on[i] = 1'b0;
        end
    endtask

    // Reference behaviour of a write strobe falling at cycle c; only chips below lim are handled.
    task automatic model_write(input logic [9:0] cs, input logic di, input logic [7:0] b,
                               input int c, input int lim);
        exp_t e;
        for (int i = 0; i < lim; i++) begin
            if (cs[i]) begin
                if (di) begin
                    e.at = c + 3 + i; e.chip = 4'(i); e.page = m_page[i];
                    e.col = m_col[i]; e.data = b;
                    sb.push_back(e);
                    if (m_up[i]) m_col[i] = (m_col[i] == 6'd49) ? 6'd0 : m_col[i] + 6'd1;
                    else         m_col[i] = (m_col[i] == 6'd0) ? 6'd49 : m_col[i] - 6'd1;
                end else begin
                    if (b == 8'h38)      m_on[i] = 1'b0;
                    else if (b == 8'h39) m_on[i] = 1'b1;
                    else if (b == 8'h3A) m_up[i] = 1'b0;
                    else if (b == 8'h3B) m_up[i] = 1'b1;
                    else if (b[5:0] == 6'h3E) begin end
                    else if (b[5:0] < 6'd50) begin
                        m_page[i] = b[7:6]; m_col[i] = b[5:0];
                    end
                end
            end
        end
    endtask

    task automatic xfer(input logic [9:0] cs, input logic rw, input logic di, input logic [7:0] b,
                        input logic rd_chk, input logic exp_oe, input logic [7:0] exp_dout);
        int c;
        bus_data = b; bus_cs = cs; bus_rw = rw; bus_di = di; bus_enable = 1'b1;
        tick(3);
        c = cyc;
        bus_enable = 1'b0;
        if (!rw) model_write(cs, di, b, c, 10);
        if (rw && rd_chk) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("status_oe", 32'(data_oe), 32'(exp_oe));
            chk("status_byte", 32'(data_out), 32'(exp_dout));
            tick(1);
            bus_enable = 1'b1;
            tick(4);
            chk("oe_release", 32'(data_oe), 32'(1'b0));
        end else begin
            tick(14);
            bus_enable = 1'b1;
            tick(3);
        end
    endtask

    // Scoreboard: every framebuffer strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && fb_we) begin
            n_we <= n_we + 1;
            if (sb.size() == 0) begin
                chk("fb_unexpected", 32'(fb_we), 32'(1'b0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("fb_cycle", 32'(cyc), 32'(e.at));
                chk("fb_chip", 32'(fb_chip), 32'(e.chip));
                chk("fb_page", 32'(fb_page), 32'(e.page));
                chk("fb_col", 32'(fb_col), 32'(e.col));
                chk("fb_data", 32'(fb_data), 32'(e.data));
            end
        end
    end

    initial begin
        int c;
        int n0;
        //         cs      rw    di    data   rd    oe    dout   on
        tbl[0]  = '{10'h001, 1'b0, 1'b0, 8'h45, 1'b0, 1'b0, 8'h00, 10'h000};
        tbl[1]  = '{10'h001, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 10'h000};
        tbl[2]  = '{10'h001, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 10'h000};
        tbl[3]  = '{10'h3FF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 10'h000};
        tbl[4]  = '{10'h008, 1'b0, 1'b0, 8'h3A, 1'b0, 1'b0, 8'h00, 10'h000};
        tbl[5]  = '{10'h008, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 10'h000};
        tbl[6]  = '{10'h008, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 10'h000};
        tbl[7]  = '{10'h008, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 10'h000};
        tbl[8]  = '{10'h008, 1'b0, 1'b0, 8'h3B, 1'b0, 1'b0, 8'h00, 10'h000};
        tbl[9]  = '{10'h008, 1'b0, 1'b0, 8'h31, 1'b0, 1'b0, 8'h00, 10'h000};
        tbl[10] = '{10'h008, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 10'h000};
        tbl[11] = '{10'h008, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 8'h00, 10'h000};
        tbl[12] = '{10'h004, 1'b0, 1'b0, 8'h39, 1'b0, 1'b0, 8'h00, 10'h004};
        tbl[13] = '{10'h004, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 8'h00, 10'h004};
        tbl[14] = '{10'h004, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h60, 10'h004};
        tbl[15] = '{10'h004, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 10'h004};
        tbl[16] = '{10'h00C, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 10'h004};
        tbl[17] = '{10'h004, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 10'h004};
        tbl[18] = '{10'h004, 1'b0, 1'b1, 8'h66, 1'b0, 1'b0, 8'h00, 10'h004};
        tbl[19] = '{10'h020, 1'b0, 1'b0, 8'h3A, 1'b0, 1'b0, 8'h00, 10'h004};
        tbl[20] = '{10'h020, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 10'h004};
        tbl[21] = '{10'h004, 1'b0, 1'b0, 8'hBE, 1'b0, 1'b0, 8'h00, 10'h004};
        tbl[22] = '{10'h000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 10'h004};
        tbl[23] = '{10'h004, 1'b0, 1'b0, 8'h38, 1'b0, 1'b0, 8'h00, 10'h000};

        m_reset();
        reset = 1'b1; bus_data = 8'h00; bus_cs = 10'h000; bus_rw = 1'b0; bus_di = 1'b0;
        bus_enable = 1'b0; bus_reset_n = 1'b1;
        tick(3);
        chk("rst_fb_we", 32'(fb_we), 32'(1'b0));
        chk("rst_fb_addr", 32'({fb_chip, fb_page, fb_col, fb_data}), 32'(0));
        chk("rst_data_oe", 32'(data_oe), 32'(1'b0));
        chk("rst_data_out", 32'(data_out), 32'(0));
        chk("rst_display_on", 32'(display_on), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(1'b0));
        reset = 1'b0;
        bus_enable = 1'b1;
        tick(4);

        for (int k = 0; k < 24; k++) begin
            xfer(tbl[k].cs, tbl[k].rw, tbl[k].di, tbl[k].data,
                 tbl[k].rd_chk, tbl[k].exp_oe, tbl[k].exp_dout);
            chk($sformatf("display_on_v%0d", k), 32'(display_on), 32'(tbl[k].exp_on));
        end
        chk("sb_drained_table", 32'(sb.size()), 32'(0));
        chk("no_overrun_yet", 32'(overrun), 32'(1'b0));

        // Second strobe falls inside a broadcast dispatch.
        n0 = n_we;
        bus_data = 8'h5A; bus_cs = 10'h3FF; bus_rw = 1'b0; bus_di = 1'b1;
        tick(3);
        c = cyc;
        bus_enable = 1'b0;
        model_write(10'h3FF, 1'b1, 8'h5A, c, 10);
        tick(1);
        bus_enable = 1'b1;
        tick(2);
        bus_enable = 1'b0;
        tick(14);
        bus_enable = 1'b1;
        tick(4);
        chk("overrun_set", 32'(overrun), 32'(1'b1));
        chk("overrun_we_count", 32'(n_we - n0), 32'(10));

        // Panel reset pulled low while chip 3 is being written.
        xfer(10'h004, 1'b0, 1'b0, 8'h39, 1'b0, 1'b0, 8'h00);
        n0 = n_we;
        bus_data = 8'hC3; bus_cs = 10'h3FF; bus_rw = 1'b0; bus_di = 1'b1;
        tick(3);
        c = cyc;
        bus_enable = 1'b0;
        model_write(10'h3FF, 1'b1, 8'hC3, c, 4);
        tick(5);
        bus_reset_n = 1'b0;
        tick(12);
        bus_reset_n = 1'b1;
        tick(4);
        bus_enable = 1'b1;
        tick(4);
        m_reset();
        chk("panel_rst_we_count", 32'(n_we - n0), 32'(4));
        chk("panel_rst_display_on", 32'(display_on), 32'(0));
        chk("panel_rst_keeps_overrun", 32'(overrun), 32'(1'b1));
        xfer(10'h001, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset while chip 2 is on the framebuffer port.
        bus_data = 8'h99; bus_cs = 10'h3FF; bus_rw = 1'b0; bus_di = 1'b1;
        tick(3);
        c = cyc;
        bus_enable = 1'b0;
        model_write(10'h3FF, 1'b1, 8'h99, c, 2);
        tick(5);
        chk("mid_dispatch_we", 32'(fb_we), 32'(1'b1));
        #1 reset = 1'b1;
        #1 chk("async_reset_we", 32'(fb_we), 32'(1'b0));
        bus_enable = 1'b1;
        tick(2);
        reset = 1'b0;
        m_reset();
        tick(4);
        chk("post_reset_overrun", 32'(overrun), 32'(1'b0));
        chk("post_reset_display_on", 32'(display_on), 32'(0));
        chk("sb_drained_final", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
